// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder: FSM encoding and width limits.
// No logic here; imported by the controller.
package serial_add_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int WIDTH_MAX = 32;

    // Bit counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/halfadd.sv
// Half adder: s = a ^ b, c = a & b.
// Latency: combinational. Backpressure: none.
module halfadd (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl_fulladd_cell.sv
// One-bit full adder built from two half adders plus an OR of their carries.
// Latency: combinational. Backpressure: none.
module fulladd_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    halfadd u_ha0 (.a(a),    .b(b),   .s(w_s0), .c(w_c0));
    halfadd u_ha1 (.a(w_s0), .b(cin), .s(s),    .c(w_c1));

    assign cout = w_c0 | w_c1;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder cell, one bit per clock, LSB first.
// Latency: WIDTH cycles from accept to out_valid. Backpressure: result held in DONE until out_ready.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_c;
    logic [WIDTH:0]   w_sum_cat;

    fulladd_cell u_fa (
        .a    (r_sh_a[0]),
        .b    (r_sh_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // Upper WIDTH bits are the sum register shifted right with the new bit at the MSB;
    // the concat form keeps the slice legal when WIDTH is 1.
    assign w_sum_cat = {w_s, r_sum_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_sum_sh <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sh_a  <= a;
                        r_sh_b  <= b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sh_a   <= r_sh_a >> 1;
                    r_sh_b   <= r_sh_b >> 1;
                    r_sum_sh <= w_sum_cat[WIDTH:1];
                    r_carry  <= w_c;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_sum   <= w_sum_cat[WIDTH:1];
                        r_cout  <= w_c;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst8_n, iv8, ir8, ov8, or8, co8, busy8;
    logic [7:0] a8, b8, sum8;
    logic       rst1_n, iv1, ir1, ov1, or1, co1, busy1;
    logic [0:0] a1, b1, sum1;

    int n_checks;
    int n_errors;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(co8), .busy(busy8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .out_valid(ov1), .out_ready(or1), .sum(sum1), .cout(co1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op8(input logic [7:0] va, input logic [7:0] vb,
                       input logic [7:0] es, input logic ec, input string tag);
        int lat;
        @(negedge clk);
        a8 = va; b8 = vb; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        check({tag, "_busy"}, 32'(busy8), 1);
        check({tag, "_in_ready_run"}, 32'(ir8), 0);
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 8);
        check({tag, "_sum"}, 32'(sum8), 32'(es));
        check({tag, "_cout"}, 32'(co8), 32'(ec));
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(ov8), 0);
        check({tag, "_in_ready_idle"}, 32'(ir8), 1);
    endtask

    task automatic op1(input logic va, input logic vb,
                       input logic es, input logic ec, input string tag);
        int lat;
        @(negedge clk);
        a1 = va; b1 = vb; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        check({tag, "_busy"}, 32'(busy1), 1);
        lat = 0;
        while (!ov1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 1);
        check({tag, "_sum"}, 32'(sum1), 32'(es));
        check({tag, "_cout"}, 32'(co1), 32'(ec));
        or1 = 1'b1;
        @(negedge clk);
        or1 = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(ov1), 0);
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_errors = 0;
        rst8_n = 1'b0; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        rst1_n = 1'b0; iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0;

        // Reset then idle
        repeat (3) @(negedge clk);
        rst8_n = 1'b1; rst1_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(ir8), 1);
        check("rst_out_valid", 32'(ov8), 0);
        check("rst_sum", 32'(sum8), 0);
        check("rst_cout", 32'(co8), 0);
        check("rst_busy", 32'(busy8), 0);
        check("rst1_in_ready", 32'(ir1), 1);

        // out_ready in IDLE must not disturb anything
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        check("idle_out_ready_noop", 32'(ir8), 1);

        op8(8'hA5, 8'h5A, 8'hFF, 1'b0, "basic");
        op8(8'hFF, 8'h01, 8'h00, 1'b1, "ovf_ff01");
        op8(8'h80, 8'h80, 8'h00, 1'b1, "ovf_8080");
        op8(8'h00, 8'h00, 8'h00, 1'b0, "zero");

        // Backpressure, ignored in_valid during RUN, operand change during RUN
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h0F; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        a8 = 8'h11; b8 = 8'h22; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        check("bp_busy_after_pulse", 32'(busy8), 1);
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("bp_out_valid", 32'(ov8), 1);
        repeat (10) @(negedge clk);
        check("bp_held_valid", 32'(ov8), 1);
        check("bp_held_sum", 32'(sum8), 32'h4B);
        check("bp_held_cout", 32'(co8), 0);
        check("bp_in_ready_done", 32'(ir8), 0);
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        check("bp_release", 32'(ov8), 0);
        op8(8'h11, 8'h22, 8'h33, 1'b0, "after_bp");

        // Reset in the middle of RUN
        @(negedge clk);
        a8 = 8'h7F; b8 = 8'h01; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before_rst", 32'(busy8), 1);
        rst8_n = 1'b0;
        #1;
        check("mid_rst_async_busy", 32'(busy8), 0);
        check("mid_rst_async_out_valid", 32'(ov8), 0);
        check("mid_rst_async_sum", 32'(sum8), 0);
        @(negedge clk);
        rst8_n = 1'b1;
        @(negedge clk);
        check("mid_rel_in_ready", 32'(ir8), 1);
        check("mid_rel_busy", 32'(busy8), 0);
        check("mid_rel_out_valid", 32'(ov8), 0);
        check("mid_rel_sum", 32'(sum8), 0);
        op8(8'h02, 8'h03, 8'h05, 1'b0, "after_rst");

        // WIDTH=1 instance
        op1(1'b1, 1'b1, 1'b0, 1'b1, "w1_11");
        op1(1'b1, 1'b0, 1'b1, 1'b0, "w1_10");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
